// File: rtl/eco32f_wb_ram_pkg.sv
// Shared Wishbone cycle-type/burst-type codes, responder state encoding and burst address helpers.
// Optional wait-state support is enabled with the macro ECO32F_WB_RAM_WAITSTATE_EN.
package eco32f_wb_ram_pkg;

  localparam logic [2:0] ECO32F_WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] ECO32F_WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] ECO32F_WB_CTI_EOB     = 3'b111;

  localparam logic [1:0] ECO32F_WB_BTE_LINEAR  = 2'b00;
  localparam logic [1:0] ECO32F_WB_BTE_WRAP4   = 2'b01;
  localparam logic [1:0] ECO32F_WB_BTE_WRAP8   = 2'b10;
  localparam logic [1:0] ECO32F_WB_BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
    ST_ERR,
    ST_WAIT
`else
    ST_ERR
`endif
  } state_t;

  // Word-address bits that take part in the burst increment; everything above is held.
  function automatic logic [29:0] wrap_mask(input logic [1:0] bte, input int aw);
    logic [29:0] m;
    m = 30'h0;
    case (bte)
      ECO32F_WB_BTE_LINEAR: m = (30'd1 << aw) - 30'd1;
      ECO32F_WB_BTE_WRAP4:  m = 30'h3;
      ECO32F_WB_BTE_WRAP8:  m = 30'h7;
      ECO32F_WB_BTE_WRAP16: m = 30'hf;
    endcase
    return m;
  endfunction

  function automatic logic [29:0] next_word(input logic [29:0] adr, input logic [1:0] bte,
                                            input int aw);
    logic [29:0] m;
    m = wrap_mask(bte, aw);
    return (adr & ~m) | ((adr + 30'd1) & m);
  endfunction

endpackage

// File: rtl/eco32f_spram.sv
// Single-port synchronous RAM: per-byte write enables, read enable, one-cycle read latency.
// The read register holds its value while re is low; only that register is reset.
module eco32f_spram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wdat,
  input  logic [3:0]    we,
  input  logic          re,
  output logic [31:0]   rdat
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[adr][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdat <= '0;
    else if (re) rdat <= mem[adr];
  end

endmodule

// File: rtl/eco32f_wb_ram.sv
// Wishbone B3 RAM responder: classic cycles, incrementing/wrapping bursts at one beat per cycle.
// Define ECO32F_WB_RAM_WAITSTATE_EN to insert WAIT_STATES idle cycles before the first ack.
module eco32f_wb_ram
  import eco32f_wb_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'he0000000,
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);

  state_t        state;
  logic [29:0]   adr_p0;
  logic          ack;
  logic          err;
  logic          in_win;
  logic          cti_incr;
  logic [29:0]   adr_next;
  logic [AW-1:0] ram_adr;
  logic [3:0]    ram_we;
  logic          ram_re;
  logic          unused_ok;

`ifdef ECO32F_WB_RAM_WAITSTATE_EN
  localparam logic [7:0] WS_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
  logic [7:0] cnt;
`endif

  assign in_win    = (wbs_adr_i[31:AW+2] == BASE_ADR[31:AW+2]);
  assign adr_next  = next_word(adr_p0, wbs_bte_i, AW);
  assign unused_ok = ^{wbs_adr_i[1:0], 1'(WAIT_STATES)};

  always_comb begin
    cti_incr = 1'b0;
    case (wbs_cti_i)
      ECO32F_WB_CTI_INCR:                      cti_incr = 1'b1;
      ECO32F_WB_CTI_CLASSIC, ECO32F_WB_CTI_EOB: cti_incr = 1'b0;
      default:                                 cti_incr = 1'b0;
    endcase
  end

  // RAM port: a completed write beat owns the port, so it always lands before any later read.
  always_comb begin
    ram_re  = 1'b0;
    ram_we  = 4'b0000;
    ram_adr = adr_p0[AW-1:0];
    if (wbs_cyc_i) begin
      case (state)
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
        ST_WAIT: if (cnt == 8'd0) ram_re = 1'b1;
`else
        ST_IDLE: if (wbs_stb_i && in_win) begin
          ram_re  = 1'b1;
          ram_adr = wbs_adr_i[AW+1:2];
        end
`endif
        ST_BEAT: begin
          if (ack && wbs_stb_i) begin
            if (wbs_we_i) begin
              ram_we = wbs_sel_i;
            end else if (cti_incr) begin
              ram_re  = 1'b1;
              ram_adr = adr_next[AW-1:0];
            end
          end else if (!ack && wbs_stb_i) begin
            ram_re = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      adr_p0 <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
      cnt    <= 8'd0;
`endif
    end else if (!wbs_cyc_i) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (wbs_stb_i) begin
            if (!in_win) begin
              state <= ST_ERR;
              err   <= 1'b1;
            end else begin
              adr_p0 <= wbs_adr_i[31:2];
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
              state  <= ST_WAIT;
              cnt    <= WS_LOAD;
`else
              state  <= ST_BEAT;
              ack    <= 1'b1;
`endif
            end
          end
        end
        ST_ERR: begin
          err   <= 1'b0;
          state <= ST_IDLE;
        end
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
        ST_WAIT: begin
          if (cnt == 8'd0) begin
            state <= ST_BEAT;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
`endif
        ST_BEAT: begin
          if (ack) begin
            if (wbs_stb_i && cti_incr) begin
              adr_p0 <= adr_next;
            end else if (wbs_stb_i) begin
              ack   <= 1'b0;
              state <= ST_IDLE;
            end else begin
              ack <= 1'b0;
            end
          end else if (wbs_stb_i) begin
            ack <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

  eco32f_spram #(.AW(AW)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .adr  (ram_adr),
    .wdat (wbs_dat_i),
    .we   (ram_we),
    .re   (ram_re),
    .rdat (wbs_dat_o)
  );

  assign wbs_ack_o = ack;
  assign wbs_err_o = err;
  assign wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_eco32f_wb_ram.sv
// Randomized bench for eco32f_wb_ram: a word-array memory model plus spec-derived beat timing,
// checked by one per-cycle compare process on the falling edge.
module tb_eco32f_wb_ram;

  localparam int DEPTH = 4096;
`ifdef ECO32F_WB_RAM_WAITSTATE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  always #5 clk = ~clk;

  eco32f_wb_ram dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel), .wbs_we_i(we),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(rdat), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty)
  );

  logic [31:0] mem [DEPTH];
  bit          known [DEPTH];

  bit          chk_en = 1'b0;
  bit          exp_ack, exp_err, exp_dchk;
  logic [31:0] exp_dat;
  string       tag = "reset";
  int          n_vec = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (ack !== exp_ack || err !== exp_err || rty !== 1'b0 || (ack && err) ||
          (exp_dchk && rdat !== exp_dat)) begin
        n_bad++;
        $display("FAIL %s @%0t: ack=%b err=%b rty=%b dat=%h, required ack=%b err=%b rty=0 dat=%h (dat checked=%b)",
                 tag, $time, ack, err, rty, rdat, exp_ack, exp_err, exp_dat, exp_dchk);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
    cyc = c; stb = s; we = w; adr = a; wdat = d; sel = sl; cti = ct; bte = bt;
  endtask

  task automatic expect_o(input bit a, input bit e, input bit dc, input logic [31:0] d);
    exp_ack = a; exp_err = e; exp_dchk = dc; exp_dat = d;
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] wadr(input int w);
    logic [11:0] lo;
    lo = w[11:0];
    return {18'h38000, lo, 2'b00};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] sl);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sl[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Burst order from the rules: linear steps modulo RAM depth, wrapN steps inside an N-word block.
  function automatic int next_word(input int w, input logic [1:0] bt);
    int n;
    case (bt)
      2'b00:   return (w + 1) % DEPTH;
      2'b01:   n = 4;
      2'b10:   n = 8;
      default: n = 16;
    endcase
    return (w - (w % n)) + ((w + 1) % n);
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
      expect_o(0, 0, 0, 32'h0);
    end
  endtask

  task automatic classic(input bit w_e, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sl, input logic [2:0] ct, input string nm);
    int w;
    bit inw;
    tag = nm;
    w = int'(a[13:2]);
    inw = (a[31:14] == 18'h38000);
    tick();
    drive(1, 1, w_e, a, d, sl, ct, 2'b00);
    expect_o(0, 0, 0, 32'h0);
    if (!inw) begin
      tick();
      expect_o(0, 1, 0, 32'h0);
      return;
    end
    for (int i = 1; i < LAT; i++) begin
      tick();
      expect_o(0, 0, 0, 32'h0);
    end
    tick();
    expect_o(1, 0, !w_e && known[w], mem[w]);
    if (w_e) begin
      mem[w] = merge(mem[w], d, sl);
      known[w] = known[w] || (sl == 4'hf);
    end
  endtask

  task automatic burst(input bit w_e, input int w0, input int n, input logic [1:0] bt,
                       input int stall_after, input int stall_len, input int rst_at,
                       input string nm);
    int w, wn;
    logic [31:0] d;
    tag = nm;
    w = w0;
    tick();
    drive(1, 1, w_e, wadr(w), 32'h0, 4'hf, (n == 1) ? 3'b111 : 3'b010, bt);
    expect_o(0, 0, 0, 32'h0);
    for (int i = 1; i < LAT; i++) begin
      tick();
      expect_o(0, 0, 0, 32'h0);
    end
    for (int b = 0; b < n; b++) begin
      tick();
      d = $urandom;
      if (b == rst_at) begin
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
        expect_o(0, 0, 1, 32'h0);
        tick();
        expect_o(0, 0, 1, 32'h0);
        tick();
        rst = 1'b1;
        expect_o(0, 0, 1, 32'h0);
        return;
      end
      drive(1, 1, w_e, wadr(w), d, 4'hf, (b == n - 1) ? 3'b111 : 3'b010, bt);
      expect_o(1, 0, !w_e && known[w], mem[w]);
      if (w_e) begin
        mem[w] = d;
        known[w] = 1'b1;
      end
      wn = next_word(w, bt);
      if (b == stall_after && b < n - 1) begin
        tick();
        stb = 1'b0;
        expect_o(1, 0, !w_e && known[wn], mem[wn]);
        for (int k = 1; k < stall_len; k++) begin
          tick();
          expect_o(0, 0, 0, 32'h0);
        end
        tick();
        stb = 1'b1;
        adr = wadr(wn);
        expect_o(0, 0, 0, 32'h0);
      end
      w = wn;
    end
  endtask

  int          want8 [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
  int          w, n, sa, sl_len, op;
  logic [1:0]  bt;
  logic [2:0]  ct;
  logic [31:0] a;

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    expect_o(0, 0, 1, 32'h0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    idle(1);

    // Hand-computed anchors for the model itself.
    pin("model merge sel0101", merge(32'h11223344, 32'haabbccdd, 4'b0101), 32'h11bb33dd);
    w = 5;
    for (int i = 0; i < 8; i++) begin
      pin("model wrap8 order", w, want8[i]);
      w = next_word(w, 2'b10);
    end
    pin("model linear top", next_word(4095, 2'b00), 0);
    pin("model wrap4", next_word(7, 2'b01), 4);
    pin("model wrap16", next_word(31, 2'b11), 16);

    classic(1, 32'he0000000, 32'h12345678, 4'hf, 3'b000, "wr word0");
    classic(0, 32'he0000000, 32'h0, 4'hf, 3'b000, "classic rd 0x12345678");
    idle(1);

    for (int i = 0; i < 8; i++) classic(1, wadr(i), i, 4'hf, 3'b000, "fill i");
    burst(0, 5, 8, 2'b10, -1, 0, -1, "wrap8 from 0x14");
    idle(1);

    classic(1, 32'he0000008, 32'h11223344, 4'hf, 3'b000, "wr 0x11223344");
    classic(1, 32'he0000008, 32'haabbccdd, 4'b0101, 3'b000, "wr sel0101");
    classic(0, 32'he0000008, 32'h0, 4'hf, 3'b000, "rd merged");
    pin("model merged word2", mem[2], 32'h11bb33dd);

    classic(1, 32'he0001000, 32'hcafef00d, 4'hf, 3'b000, "wr 0x400");
    classic(1, 32'h00001000, 32'hdeadbeef, 4'hf, 3'b000, "err write");
    classic(0, 32'h00001000, 32'h0, 4'hf, 3'b000, "err read");
    classic(1, 32'he0004000, 32'h55555555, 4'hf, 3'b000, "err window edge");
    idle(1);
    classic(0, 32'he0001000, 32'h0, 4'hf, 3'b000, "rd 0x400 unchanged");
    classic(0, 32'he0000000, 32'h0, 4'hf, 3'b111, "rd word0 unchanged");

    for (int i = 8; i < 80; i++) classic(1, wadr(i), $urandom, 4'hf, 3'b000, "fill rand");
    burst(0, 8, 8, 2'b10, 1, 2, -1, "stall burst");
    classic(1, wadr(4094), $urandom, 4'hf, 3'b000, "fill top");
    classic(1, wadr(4095), $urandom, 4'hf, 3'b000, "fill top");
    burst(0, 4094, 4, 2'b00, -1, 0, -1, "linear wrap at depth");
    burst(1, 20, 6, 2'b00, 2, 1, -1, "write burst");
    burst(0, 16, 16, 2'b11, -1, 0, -1, "wrap16 readback");
    burst(0, 8, 8, 2'b00, -1, 0, 3, "reset mid burst");
    classic(0, 32'he0000000, 32'h0, 4'hf, 3'b000, "rd after reset");

    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          do ct = 3'($urandom); while (ct == 3'b010);
          classic(0, wadr($urandom_range(0, 79)), 32'h0, 4'hf, ct, "rand classic rd");
        end
        1: classic(1, wadr($urandom_range(0, 79)), $urandom, 4'($urandom), 3'b000,
                   "rand classic wr");
        2, 3, 4: begin
          bt = 2'($urandom);
          n = $urandom_range(1, 8);
          w = (bt == 2'b00) ? $urandom_range(0, 63) : $urandom_range(0, 79);
          sa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
          sl_len = $urandom_range(1, 3);
          burst(op == 4, w, n, bt, sa, sl_len, -1, (op == 4) ? "rand burst wr" : "rand burst rd");
        end
        default: begin
          do a = $urandom; while (a[31:14] == 18'h38000);
          classic($urandom_range(0, 1) == 1, a, $urandom, 4'hf, 3'b000, "rand out of window");
        end
      endcase
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
